wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between two sources. The primary source is the in-order pipeline writeback, taken from the WB end registers. The secondary source is a long-latency multi-cycle unit (mul/div/load-miss) using a valid/ready handshake. The pipeline has priority; a starvation counter forces a one-cycle pipeline stall so the multi-cycle result is retired.

Parameters:
DATA_W, 16, register data width
REG_AW, 3, register number width (8 registers)
STARVE_LIMIT, 4, cycles mc_valid may wait unserved before a forced grant; legal range 1..15
CNT_W, 4, width of the wait counter; must hold STARVE_LIMIT

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
pipe_wr_en  in  1  pipeline WB write request (Reg_write_out)
pipe_rd  in  REG_AW  pipeline destination register number
pipe_data  in  DATA_W  pipeline writeback data
mc_valid  in  1  multi-cycle unit has a result
mc_rd  in  REG_AW  multi-cycle destination register
mc_data  in  DATA_W  multi-cycle result
mc_ready  out  1  multi-cycle result accepted this cycle
pipe_stall  out  1  hold all pipeline register enables low this cycle
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  REG_AW  register-file write address (registered)
rf_wdata  out  DATA_W  register-file write data (registered)

Behaviour:
- One clock, clock; reset clear_n is asynchronous and active-low. While clear_n=0:
  - state=ARB, wait_cnt=0
  - rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, mc_ready=0
- FSM has 2 states: ARB and FORCE. pipe_stall = (state==FORCE).
- ARB, grant decision (combinational):
  - pipe_wr_en=1: pipe wins, mc_ready=0.
  - pipe_wr_en=0 and mc_valid=1: mc wins, mc_ready=1.
  - neither requests: no grant, rf_we=0 next cycle.
- ARB, counter: when mc_valid=1 and mc_ready=0, wait_cnt increments. When mc_ready=1 or mc_valid=0, wait_cnt clears to 0.
- ARB→FORCE: when mc_valid=1, mc_ready=0 and wait_cnt==STARVE_LIMIT-1, i.e. after STARVE_LIMIT lost cycles.
- FORCE, for exactly one cycle:
  - pipe_stall=1; pipe inputs are ignored and the pipeline re-presents the same write next cycle.
  - mc_ready=mc_valid.
  - Next state is ARB with wait_cnt=0.
  - FORCE is entered on registered state, so the stall is timing-clean.
  - If mc_valid dropped (protocol violation), the stall still occurs with no write.
- Handshake: mc_valid, once high, holds with stable mc_rd/mc_data until mc_ready=1. A transfer occurs on a cycle where mc_valid&&mc_ready.
- Latency: a winner's rd/data appear on rf_waddr/rf_wdata with rf_we=1 one clock after the grant cycle.
- Back-to-back grants are allowed each cycle; no bubbles are inserted except the FORCE stall.
- Same rd from both sources in the same cycle: only the winner writes, with no merging. Ordering correctness is the issue logic's responsibility.
- Reset asserted mid-FORCE: stall deasserts immediately (async), the pending mc result stays unaccepted, and wait_cnt restarts from 0.

Optional Feature:
WB_ARB_PERF_EN. When defined, adds output ports:
- stall_cnt [15:0]: counts FORCE cycles.
- mc_wait_cnt [15:0]: counts cycles with mc_valid&&!mc_ready.
Both reset to 0 on clear_n and saturate at 16'hFFFF. When undefined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds: DATA_W and REG_AW constants, the arbiter state enum (ARB, FORCE), and STARVE_LIMIT default.
- Output register uses the existing reg_16bit register (parameterised widths 1, REG_AW, DATA_W) with enable tied high and reset driven by ~clear_n.
- FSM and counter live in the top module; no other sub-module is needed.

Test Plan:
- Reset: hold clear_n=0 with all inputs active -> rf_we=0, mc_ready=0, pipe_stall=0. Release -> first grant registers one clock later.
- Idle pipe: pipe_wr_en=0; mc_valid=1, mc_rd=3'd5, mc_data=16'hBEEF -> mc_ready=1 same cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=16'hBEEF.
- Pipe priority: pipe_wr_en=1 (rd=2, data=16'h1234) together with mc_valid=1 -> rf_waddr=2, rf_wdata=16'h1234, mc_ready=0.
- Starvation with STARVE_LIMIT=4: pipe_wr_en=1 continuously and mc_valid=1 (rd=7, data=16'hA5A5) -> mc_ready=0 for 4 cycles. Cycle 5 gives pipe_stall=1 and mc_ready=1. Cycle 6 gives rf_waddr=7 and pipe_stall=0. Pipe writes resume without loss.
- Reset mid-FORCE: pull clear_n low during the FORCE cycle -> pipe_stall and mc_ready go to 0 asynchronously. After release, the full STARVE_LIMIT wait is needed before the next FORCE.
- With WB_ARB_PERF_EN defined, run the starvation scenario 3 times -> stall_cnt=3 and mc_wait_cnt=12.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Brief    : Shared constants and arbiter state type for the register-file
//            write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int c_data_w       = 16;  // register data width
    localparam int c_reg_aw       = 3;   // register number width (8 registers)
    localparam int c_starve_limit = 4;   // lost cycles before a forced grant
    localparam int c_cnt_w        = 4;   // wait counter width

    // ARB: normal priority arbitration; FORCE: one-cycle pipeline stall
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        FORCE = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_if
// Brief    : Pipeline writeback, multi-cycle handshake and register-file
//            write bundle seen by the write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int REG_AW = c_reg_aw
) ();

    logic              pipe_wr_en;
    logic [REG_AW-1:0] pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              mc_valid;
    logic [REG_AW-1:0] mc_rd;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              pipe_stall;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Sources and register file side
    modport master (
        output pipe_wr_en, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        input  mc_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side
    modport slave (
        input  pipe_wr_en, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        output mc_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
    );

endinterface
`default_nettype wire

// File: rtl/reg_16bit.sv
`default_nettype none
// ============================================================================
// Module   : reg_16bit
// Brief    : Width-parameterised enabled register with asynchronous
//            active-high reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_16bit #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    // Capture the input when enabled; clear immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Arbitrates the single register-file write port between the
//            in-order pipeline writeback (priority) and a long-latency
//            multi-cycle unit. A starvation counter forces a one-cycle
//            pipeline stall so a waiting multi-cycle result is retired.
//            Optional macro WB_ARB_PERF_EN adds saturating stall / wait
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = c_data_w,
    parameter int REG_AW       = c_reg_aw,
    parameter int STARVE_LIMIT = c_starve_limit,  // legal 1..15
    parameter int CNT_W        = c_cnt_w
) (
    input  wire logic         clock,
    input  wire logic         clear_n,
    wb_port_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       mc_wait_cnt
`endif
);

    // Counter value on the last lost cycle before a forced grant
    localparam logic [CNT_W-1:0] c_starve_last = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_next_cnt;
    logic              w_sel_pipe;
    logic              w_mc_ready;
    logic              w_mc_grant;
    logic              w_we;
    logic [REG_AW-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rst;

    // State and starvation counter register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state    <= ARB;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
        end
    end

    // Grant decision, starvation counting and next state
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_wait_cnt;
        w_sel_pipe   = 1'b0;
        w_mc_ready   = 1'b0;
        case (r_state)
            ARB: begin
                if (bus.pipe_wr_en) begin
                    w_sel_pipe = 1'b1;
                end else if (bus.mc_valid) begin
                    w_mc_ready = 1'b1;
                end
                if (bus.mc_valid && !w_mc_ready) begin
                    if (r_wait_cnt == c_starve_last) begin
                        w_next_state = FORCE;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_wait_cnt + CNT_W'(1);
                    end
                end else begin
                    w_next_cnt = '0;
                end
            end
            FORCE: begin
                // Pipeline is held this cycle; its inputs are ignored
                w_mc_ready   = bus.mc_valid;
                w_next_state = ARB;
                w_next_cnt   = '0;
            end
            default: begin
                w_next_state = ARB;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Ready is held low for the whole reset window, whatever the inputs
    assign w_mc_grant     = clear_n & w_mc_ready;
    assign bus.mc_ready   = w_mc_grant;
    assign bus.pipe_stall = (r_state == FORCE);

    // Write-port mux; an idle cycle presents zeros with the enable low
    assign w_we    = w_sel_pipe | w_mc_grant;
    assign w_waddr = w_sel_pipe ? bus.pipe_rd   : (w_mc_grant ? bus.mc_rd   : '0);
    assign w_wdata = w_sel_pipe ? bus.pipe_data : (w_mc_grant ? bus.mc_data : '0);
    assign w_rst   = ~clear_n;

    reg_16bit #(.WIDTH(1)) u_rf_we (
        .clk  (clock),
        .rst  (w_rst),
        .i_en (1'b1),
        .i_d  (w_we),
        .o_q  (bus.rf_we)
    );

    reg_16bit #(.WIDTH(REG_AW)) u_rf_waddr (
        .clk  (clock),
        .rst  (w_rst),
        .i_en (1'b1),
        .i_d  (w_waddr),
        .o_q  (bus.rf_waddr)
    );

    reg_16bit #(.WIDTH(DATA_W)) u_rf_wdata (
        .clk  (clock),
        .rst  (w_rst),
        .i_en (1'b1),
        .i_d  (w_wdata),
        .o_q  (bus.rf_wdata)
    );

`ifdef WB_ARB_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_mc_wait_cnt;

    // Saturating counts of forced stalls and of lost multi-cycle cycles
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_stall_cnt   <= '0;
            r_mc_wait_cnt <= '0;
        end else begin
            if ((r_state == FORCE) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (bus.mc_valid && !w_mc_grant && (r_mc_wait_cnt != 16'hFFFF)) begin
                r_mc_wait_cnt <= r_mc_wait_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign mc_wait_cnt = r_mc_wait_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Scoreboard bench for wb_port_arbiter with a lost-cycle reference
//            model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int SL = 4;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clock   = 1'b0;
    logic clear_n = 1'b0;
    always #5 clock = ~clock;

    wb_port_arbiter_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] mc_wait_cnt;
`endif

    wb_port_arbiter #(
        .DATA_W       (DW),
        .REG_AW       (AW),
        .STARVE_LIMIT (SL),
        .CNT_W        (4)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .mc_wait_cnt (mc_wait_cnt)
`endif
    );

    // Scoreboard and counters
    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model: consecutive cycles the multi-cycle result has waited
    int  lost     = 0;
    int  m_stalls = 0;
    int  m_waits  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One arbitration cycle: drive inputs, check same-cycle outputs, record
    // the expected register-file write and advance the model.
    task automatic cycle(input bit pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pdata,
                         input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdata,
                         output bit stall, output bit acc);
        @(negedge clock);
        bus.pipe_wr_en = pwe;
        bus.pipe_rd    = prd;
        bus.pipe_data  = pdata;
        bus.mc_valid   = mv;
        bus.mc_rd      = mrd;
        bus.mc_data    = mdata;
        #1;
        stall = (lost == SL);
        acc   = mv && (stall || !pwe);
        check("pipe_stall", {31'd0, bus.pipe_stall}, {31'd0, stall});
        check("mc_ready",   {31'd0, bus.mc_ready},   {31'd0, acc});
        if (!stall && pwe) exp_q.push_back('{rd: prd, data: pdata});
        else if (acc)      exp_q.push_back('{rd: mrd, data: mdata});
        if (stall) m_stalls++;
        if (mv && !acc) begin
            lost++;
            m_waits++;
        end else begin
            lost = 0;
        end
    endtask

    // Pipeline writes every cycle while a multi-cycle result waits; returns
    // how many cycles the result took to be accepted.
    task automatic starve_run(input logic [AW-1:0] mrd, input logic [DW-1:0] mdata,
                              input logic [AW-1:0] first_rd, input logic [DW-1:0] first_data,
                              output int ncyc);
        bit st;
        bit acc;
        bit prev_st = 1'b0;
        logic [AW-1:0] prd = first_rd;
        logic [DW-1:0] pd  = first_data;
        ncyc = 0;
        acc  = 1'b0;
        while (!acc && ncyc < 12) begin
            if (ncyc != 0 && !prev_st) begin
                prd = AW'($urandom);
                pd  = DW'($urandom);
            end
            cycle(1'b1, prd, pd, 1'b1, mrd, mdata, st, acc);
            prev_st = st;
            ncyc++;
        end
        // The pipeline re-presents the write it was holding during the stall
        cycle(1'b1, prd, pd, 1'b0, '0, '0, st, acc);
    endtask

    // Monitor: every register-file write must match the oldest expectation
    initial begin
        wr_t e;
        forever begin
            @(posedge clock);
            #1;
            if (clear_n && bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rf_write: got write addr %0h data %0h, required no write",
                             bus.rf_waddr, bus.rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_waddr", {29'd0, bus.rf_waddr}, {29'd0, e.rd});
                    check("rf_wdata", {16'd0, bus.rf_wdata}, {16'd0, e.data});
                end
            end
        end
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        bit st;
        bit acc;
        int ncyc;
        bit mc_pending = 1'b0;
        bit last_stall = 1'b0;
        logic [AW-1:0] m_rd = '0;
        logic [DW-1:0] m_dat = '0;
        bit p_we = 1'b0;
        logic [AW-1:0] p_rd = '0;
        logic [DW-1:0] p_dat = '0;

        // Reset held with all requests active
        bus.pipe_wr_en = 1'b1;
        bus.pipe_rd    = 3'd1;
        bus.pipe_data  = 16'hFFFF;
        bus.mc_valid   = 1'b1;
        bus.mc_rd      = 3'd4;
        bus.mc_data    = 16'h5555;
        #12;
        check("reset_rf_we",      {31'd0, bus.rf_we},      32'd0);
        check("reset_rf_waddr",   {29'd0, bus.rf_waddr},   32'd0);
        check("reset_rf_wdata",   {16'd0, bus.rf_wdata},   32'd0);
        check("reset_pipe_stall", {31'd0, bus.pipe_stall}, 32'd0);
        check("reset_mc_ready",   {31'd0, bus.mc_ready},   32'd0);
        bus.pipe_wr_en = 1'b0;
        #1;
        check("reset_mc_ready_idle_pipe", {31'd0, bus.mc_ready}, 32'd0);
        bus.mc_valid = 1'b0;
        #10;
        clear_n = 1'b1;

        // Idle pipeline: multi-cycle result accepted at once
        cycle(1'b0, '0, '0, 1'b1, 3'd5, 16'hBEEF, st, acc);
        check("idle_accept", {31'd0, acc}, 32'd1);

        // Starvation three times; the first cycle also shows pipe priority
        starve_run(3'd7, 16'hA5A5, 3'd2, 16'h1234, ncyc);
        check("starve_len_1", ncyc, SL + 1);
        starve_run(3'd7, 16'hA5A5, 3'd3, 16'h0F0F, ncyc);
        check("starve_len_2", ncyc, SL + 1);
        starve_run(3'd1, 16'h3C3C, 3'd1, 16'hC3C3, ncyc);
        check("starve_len_3", ncyc, SL + 1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, st, acc);
`ifdef WB_ARB_PERF_EN
        check("perf_stall_cnt_3runs",   {16'd0, stall_cnt},   32'd3);
        check("perf_mc_wait_cnt_3runs", {16'd0, mc_wait_cnt}, 32'd12);
`endif

        // Reset asserted during the forced cycle
        ncyc = 0;
        while (lost != SL && ncyc < 10) begin
            cycle(1'b1, 3'd0, 16'h0001, 1'b1, 3'd6, 16'h5A5A, st, acc);
            ncyc++;
        end
        cycle(1'b1, 3'd0, 16'h0001, 1'b1, 3'd6, 16'h5A5A, st, acc);
        check("force_reached", {31'd0, st}, 32'd1);
        #1;
        clear_n = 1'b0;
        #1;
        check("midforce_pipe_stall", {31'd0, bus.pipe_stall}, 32'd0);
        check("midforce_mc_ready",   {31'd0, bus.mc_ready},   32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        lost     = 0;
        m_stalls = 0;
        m_waits  = 0;
        @(posedge clock);
        #3;
        clear_n = 1'b1;
        starve_run(3'd6, 16'h5A5A, 3'd0, 16'h0001, ncyc);
        check("post_reset_starve_len", ncyc, SL + 1);

        // Randomized traffic honouring the valid/ready and stall protocols
        for (int i = 0; i < 400; i++) begin
            if (!mc_pending && $urandom_range(0, 2) != 0) begin
                mc_pending = 1'b1;
                m_rd  = AW'($urandom);
                m_dat = DW'($urandom);
            end
            if (!last_stall) begin
                p_we  = ($urandom_range(0, 4) != 0);
                p_rd  = AW'($urandom);
                p_dat = DW'($urandom);
            end
            cycle(p_we, p_rd, p_dat, mc_pending, m_rd, m_dat, st, acc);
            if (acc) mc_pending = 1'b0;
            last_stall = st;
        end

        // Drain and final checks
        cycle(1'b0, '0, '0, 1'b0, '0, '0, st, acc);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, st, acc);
        @(posedge clock);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);
`ifdef WB_ARB_PERF_EN
        check("perf_stall_cnt",   {16'd0, stall_cnt},   m_stalls);
        check("perf_mc_wait_cnt", {16'd0, mc_wait_cnt}, m_waits);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
